// File: rtl/fp_add_pipe.sv
// fp_add_pipe: 3-stage pipelined float adder, flush-to-zero.
// Ports: clk, rst (sync, high), in_valid/in_ready, a, b in;
//   out_valid/out_ready, result (a+b), ovf (finite overflow) out.
// Macro FP_ADD_PIPE_RNE_EN: round nearest-even (else truncate).
module fp_add_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         ovf
);
`ifdef FP_ADD_PIPE_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif
  // hidden + mantissa + guard/round/sticky
  localparam int XW = MAN_W + 4;
  localparam int SW = XW + 1;
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam logic [EXP_W-1:0] SMAX = EXP_W'(MAN_W + 3);
  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             sgn;
    logic             sub;
    logic             spec;
    logic [W-1:0]     sval;
    logic [EXP_W-1:0] exp;
    logic [XW-1:0]    big;
    logic [XW-1:0]    sml;
  } s1_t;

  typedef struct packed {
    logic             sgn;
    logic             zsg;
    logic             spec;
    logic [W-1:0]     sval;
    logic [EXP_W-1:0] exp;
    logic [SW-1:0]    sum;
  } s2_t;

  logic v1, v2, v3;
  logic en1, en2, en3;
  s1_t  s1_d, r1;
  s2_t  s2_d, r2;
  logic [W-1:0] res_d;
  logic         ovf_d;

  assign en3 = !v3 || out_ready;
  assign en2 = !v2 || en3;
  assign en1 = !v1 || en2;
  assign in_ready  = en1;
  assign out_valid = v3;

  // S1: unpack, order by magnitude, align smaller operand
  logic sa, sb, za, zb, ia, ib, nan;
  logic [EXP_W-1:0] ea, eb, es, d, dd;
  logic [MAN_W-1:0] ma, mb;
  logic [W-2:0]  ka, kb;
  logic [XW-1:0] xa, xb, xs, mask;
  logic swap;

  assign {sa, ea, ma} = a;
  assign {sb, eb, mb} = b;
  assign za = ea == '0;
  assign zb = eb == '0;
  assign ia = &ea && mb == mb && ma == '0;
  assign ib = &eb && mb == '0;
  assign nan = (&ea && ma != '0) || (&eb && mb != '0)
             || (ia && ib && sa != sb);
  // subnormals are treated as zero magnitude
  assign ka = za ? '0 : a[W-2:0];
  assign kb = zb ? '0 : b[W-2:0];
  assign xa = za ? '0 : {1'b1, ma, 3'b000};
  assign xb = zb ? '0 : {1'b1, mb, 3'b000};
  assign swap = kb > ka;
  assign xs = swap ? xa : xb;
  assign es = swap ? ea : eb;
  assign d  = (swap ? eb : ea) - es;
  assign dd = (d > SMAX) ? SMAX : d;
  assign mask = ~({XW{1'b1}} << dd);

  always_comb begin
    s1_d      = '0;
    s1_d.sgn  = swap ? sb : sa;
    s1_d.sub  = sa ^ sb;
    s1_d.exp  = swap ? eb : ea;
    s1_d.big  = swap ? xb : xa;
    s1_d.sml  = (xs >> dd) | XW'(|(xs & mask));
    unique case (1'b1)
      nan: begin
        s1_d.spec = 1'b1;
        s1_d.sval = QNAN;
      end
      !nan && ia: begin
        s1_d.spec = 1'b1;
        s1_d.sval = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
      !nan && !ia && ib: begin
        s1_d.spec = 1'b1;
        s1_d.sval = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
      default: ;
    endcase
  end

  // S2: magnitude add/subtract; big >= sml so no borrow out
  always_comb begin
    s2_d      = '0;
    s2_d.sgn  = r1.sgn;
    // exact zero: +0 on cancellation, shared sign for 0+0
    s2_d.zsg  = r1.sub ? 1'b0 : r1.sgn;
    s2_d.spec = r1.spec;
    s2_d.sval = r1.sval;
    s2_d.exp  = r1.exp;
    if (r1.sub)
      s2_d.sum = {1'b0, r1.big} - {1'b0, r1.sml};
    else
      s2_d.sum = {1'b0, r1.big} + {1'b0, r1.sml};
  end

  // S3: normalise, round, pack
  logic [XW-1:0]    norm;
  logic [MAN_W+1:0] rm;
  logic inc, hit, zero, uf, of;
  int   e, lz;

  always_comb begin
    lz  = 0;
    hit = 1'b0;
    for (int i = XW - 1; i >= 0; i--) begin
      if (!hit && !r2.sum[i]) lz = lz + 1;
      if (r2.sum[i]) hit = 1'b1;
    end
    e    = int'(r2.exp);
    norm = '0;
    if (r2.sum[SW-1]) begin
      norm = r2.sum[SW-1:1] | XW'(r2.sum[0]);
      e    = e + 1;
    end else begin
      norm = r2.sum[XW-1:0] << lz;
      e    = e - lz;
    end
    inc = RNE & norm[2] & (norm[3] | norm[1] | norm[0]);
    rm  = {1'b0, norm[XW-1:3]} + (MAN_W+2)'(inc);
    if (rm[MAN_W+1]) begin
      rm = rm >> 1;
      e  = e + 1;
    end
    zero  = r2.sum == '0;
    uf    = e <= 0;
    of    = e >= EMAX;
    res_d = '0;
    ovf_d = 1'b0;
    unique case (1'b1)
      r2.spec: res_d = r2.sval;
      !r2.spec && zero: res_d = {r2.zsg, {(W-1){1'b0}}};
      !r2.spec && !zero && uf:
        res_d = {r2.sgn, {(W-1){1'b0}}};
      !r2.spec && !zero && !uf && of: begin
        ovf_d = 1'b1;
        if (RNE)
          res_d = {r2.sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else
          res_d = {r2.sgn, EXP_W'(EMAX - 1), {MAN_W{1'b1}}};
      end
      default:
        res_d = {r2.sgn, EXP_W'(e), rm[MAN_W-1:0]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
    end else begin
      if (en1) v1 <= in_valid;
      if (en2) v2 <= v1;
      if (en3) begin
        v3 <= v2;
        if (v2) begin
          result <= res_d;
          ovf    <= ovf_d;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en1 && in_valid) r1 <= s1_d;
    if (en2 && v1) r2 <= s2_d;
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: scoreboard bench for fp_add_pipe.
// Binary16 and binary32 instances; directed vectors.
module tb_fp_add_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, ovf;
  logic [15:0] a = '0, b = '0, result;

  logic in_valid32 = 1'b0, out_ready32 = 1'b1;
  logic in_ready32, out_valid32, ovf32;
  logic [31:0] a32 = '0, b32 = '0, result32;

  fp_add_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf)
  );

  fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .result(result32), .ovf(ovf32)
  );

`ifdef FP_ADD_PIPE_RNE_EN
  localparam logic [15:0] R_TIE = 16'h3C02;
  localparam logic [15:0] R_OVF = 16'h7C00;
`else
  localparam logic [15:0] R_TIE = 16'h3C01;
  localparam logic [15:0] R_OVF = 16'h7BFF;
`endif

  typedef struct {
    logic [15:0] res;
    logic        o;
    int          t;
    bit          lat;
    int          id;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int errors = 0, checks = 0, cyc = 0, tag = 0;
  logic pv = 1'b0, pr = 1'b0, prst = 1'b1, povf = 1'b0;
  logic [15:0] pres = '0;

  always @(negedge clk) begin
    cyc++;
    if (pv && !pr && !prst) begin
      checks++;
      if (!out_valid || result !== pres || ovf !== povf) begin
        errors++;
        $display("FAIL stall_hold got v=%b r=%h o=%b want v=1 r=%h o=%b",
                 out_valid, result, ovf, pres, povf);
      end
    end
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out got %h want none", result);
      end else begin
        e = sbq.pop_front();
        if (result !== e.res) begin
          errors++;
          $display("FAIL result id=%0d got %h want %h",
                   e.id, result, e.res);
        end
        checks++;
        if (ovf !== e.o) begin
          errors++;
          $display("FAIL ovf id=%0d got %b want %b", e.id, ovf, e.o);
        end
        if (e.lat) begin
          checks++;
          if (cyc - e.t != 3) begin
            errors++;
            $display("FAIL latency id=%0d got %0d want 3",
                     e.id, cyc - e.t);
          end
        end
      end
    end
    pv = out_valid;
    pr = out_ready;
    prst = rst;
    pres = result;
    povf = ovf;
  end

  // entered and left just after a rising edge; in_valid stays high
  task automatic issue(input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] r, input logic o,
                       input bit lat);
    in_valid = 1'b1;
    a = x;
    b = y;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      #1;
      if (in_ready) begin
        sbq.push_back('{r, o, cyc, lat, tag});
        tag++;
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL issue_timeout got no in_ready want accept");
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && sbq.size() != 0; n++)
      @(posedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", sbq.size());
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  bit seen;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    issue(16'h3C00, 16'h3C00, 16'h4000, 1'b0, 1);
    issue(16'h4000, 16'h3C00, 16'h4200, 1'b0, 1);
    issue(16'h3C01, 16'h1000, R_TIE, 1'b0, 1);
    issue(16'h7BFF, 16'h7BFF, R_OVF, 1'b1, 1);
    issue(16'h7C00, 16'hFC00, 16'h7E00, 1'b0, 1);
    issue(16'h3C00, 16'hBC00, 16'h0000, 1'b0, 1);
    issue(16'h8000, 16'h8000, 16'h8000, 1'b0, 1);
    issue(16'h7C00, 16'h3C00, 16'h7C00, 1'b0, 1);
    issue(16'h7E00, 16'h3C00, 16'h7E00, 1'b0, 1);
    issue(16'h0200, 16'h0200, 16'h0000, 1'b0, 1);
    issue(16'h8401, 16'h0400, 16'h8000, 1'b0, 1);
    in_valid = 1'b0;
    drain();

    fork
      begin
        issue(16'h3C00, 16'h3C00, 16'h4000, 1'b0, 0);
        issue(16'h4000, 16'h3C00, 16'h4200, 1'b0, 0);
        issue(16'h4000, 16'h4000, 16'h4400, 1'b0, 0);
        issue(16'h4400, 16'h3C00, 16'h4500, 1'b0, 0);
        issue(16'h3800, 16'h3800, 16'h3C00, 1'b0, 0);
        issue(16'h4200, 16'hBC00, 16'h4000, 1'b0, 0);
        issue(16'h4500, 16'hC400, 16'h3C00, 1'b0, 0);
        issue(16'h3C00, 16'h0000, 16'h3C00, 1'b0, 0);
        issue(16'hC000, 16'hC000, 16'hC400, 1'b0, 0);
        issue(16'h3C00, 16'hB800, 16'h3800, 1'b0, 0);
        in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 48; i++) begin
          out_ready = pat[i % 4];
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    out_ready = 1'b0;
    issue(16'h3C00, 16'h3C00, 16'h4000, 1'b0, 0);
    issue(16'h4000, 16'h4000, 16'h4400, 1'b0, 0);
    issue(16'h3800, 16'h3800, 16'h3C00, 1'b0, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    issue(16'h4000, 16'h3C00, 16'h4200, 1'b0, 1);
    in_valid = 1'b0;
    drain();

    in_valid32 = 1'b1;
    a32 = 32'h3F800000;
    b32 = 32'h40000000;
    @(negedge clk);
    chk("fp32_in_ready", 32'(in_ready32), 32'd1);
    @(posedge clk);
    #1;
    in_valid32 = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (out_valid32) begin
        seen = 1'b1;
        chk("fp32_result", result32, 32'h40400000);
        chk("fp32_ovf", 32'(ovf32), 32'd0);
      end
    end
    chk("fp32_seen", 32'(seen), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
